// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer.
//   ROB_SIZE   - number of entries (power of two)
//   ROB_W      - width of every rob_pos index
//   rob_type_e - kind of an allocated entry (register write, store, branch)
package reorder_buffer_pkg;

  localparam int ROB_SIZE = 16;
  localparam int ROB_W    = 4;

  typedef enum logic [1:0] {
    ROB_REG   = 2'd0,
    ROB_STORE = 2'd1,
    ROB_BR    = 2'd2
  } rob_type_e;

endpackage

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer. Allocates one entry per issued
// instruction, collects ALU / LSB write-back results, retires at most one
// entry per cycle in program order and flushes on a mispredicted branch.
// Ports:
//   clk, rst (async active-low), rdy (global stall when 0)
//   issue*          - allocation request from the decoder
//   issue_rob_pos   - tail index for the next allocation (combinational)
//   full            - no free entry
//   alu_*, lsb_*    - write-back buses
//   rs1_*, rs2_*    - operand queries with same-cycle bus forwarding
//   commit*         - registered retirement pulse and its payload
//   rollback*       - registered flush pulse and fetch redirect target
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue,
  input  logic [1:0]       issue_type,
  input  logic [4:0]       issue_rd,
  input  logic [31:0]      issue_pc,
  input  logic             issue_pred_jump,
  input  logic             issue_ready,
  input  logic [31:0]      issue_val,
  output logic [ROB_W-1:0] issue_rob_pos,
  output logic             full,
  input  logic             alu_result,
  input  logic [ROB_W-1:0] alu_rob_pos,
  input  logic [31:0]      alu_val,
  input  logic             alu_real_jump,
  input  logic [31:0]      alu_resume_pc,
  input  logic             lsb_result,
  input  logic [ROB_W-1:0] lsb_rob_pos,
  input  logic [31:0]      lsb_val,
  input  logic [ROB_W-1:0] rs1_rob_pos,
  output logic             rs1_ready,
  output logic [31:0]      rs1_val,
  input  logic [ROB_W-1:0] rs2_rob_pos,
  output logic             rs2_ready,
  output logic [31:0]      rs2_val,
  output logic             commit,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_val,
  output logic [ROB_W-1:0] commit_rob_pos,
  output logic             commit_store,
  output logic             rollback,
  output logic [31:0]      rollback_pc
);

  logic [ROB_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [ROB_W:0]      count_q, count_d;
  logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;

  // Per-field entry storage indexed by rob_pos.
  logic [1:0]  kind_q   [ROB_SIZE];
  logic [4:0]  rd_q     [ROB_SIZE];
  logic [31:0] val_q    [ROB_SIZE];
  logic        pred_q   [ROB_SIZE];
  logic        real_q   [ROB_SIZE];
  logic [31:0] resume_q [ROB_SIZE];

  logic             commit_q, commit_store_q, rollback_q;
  logic [4:0]       commit_rd_q;
  logic [31:0]      commit_val_q, rollback_pc_q;
  logic [ROB_W-1:0] commit_rob_pos_q;

  logic issue_ok, alu_ok, lsb_ok, retire, mispredict;

  // The redirect target always comes from the ALU, so the PC is not stored.
  logic unused_pc;
  assign unused_pc = ^issue_pc;

  assign full          = (count_q == (ROB_W+1)'(ROB_SIZE));
  assign issue_rob_pos = tail_q;

  // Everything arriving during the flush cycle belongs to the wrong path.
  assign issue_ok = issue & ~full & ~rollback_q;
  assign alu_ok   = alu_result & busy_q[alu_rob_pos] & ~rollback_q;
  assign lsb_ok   = lsb_result & busy_q[lsb_rob_pos] & ~rollback_q;

  // Retirement looks only at registered state: a same-cycle write-back
  // to the head retires on the following edge.
  assign retire     = (count_q != '0) & busy_q[head_q] & ready_q[head_q];
  assign mispredict = retire & (kind_q[head_q] == ROB_BR)
                      & (pred_q[head_q] != real_q[head_q]);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    if (mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      busy_d  = '0;
      ready_d = '0;
    end else begin
      if (issue_ok) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = issue_ready;
        tail_d          = tail_q + ROB_W'(1);
      end
      if (lsb_ok) ready_d[lsb_rob_pos] = 1'b1;
      if (alu_ok) ready_d[alu_rob_pos] = 1'b1;
      if (retire) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + ROB_W'(1);
      end
      case ({issue_ok, retire})
        2'b10:   count_d = count_q + (ROB_W+1)'(1);
        2'b01:   count_d = count_q - (ROB_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      busy_q           <= '0;
      ready_q          <= '0;
      commit_q         <= 1'b0;
      commit_store_q   <= 1'b0;
      commit_rd_q      <= '0;
      commit_val_q     <= '0;
      commit_rob_pos_q <= '0;
      rollback_q       <= 1'b0;
      rollback_pc_q    <= '0;
    end else if (rdy) begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      commit_q       <= retire;
      commit_store_q <= retire & (kind_q[head_q] == ROB_STORE);
      rollback_q     <= mispredict;
      if (retire) begin
        commit_rd_q      <= (kind_q[head_q] == ROB_STORE) ? 5'd0 : rd_q[head_q];
        commit_val_q     <= val_q[head_q];
        commit_rob_pos_q <= head_q;
      end
      if (mispredict) rollback_pc_q <= resume_q[head_q];
    end
  end

  // Payload storage needs no reset: busy/ready gate every use of it.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (issue_ok) begin
        kind_q[tail_q] <= issue_type;
        rd_q[tail_q]   <= issue_rd;
        val_q[tail_q]  <= issue_val;
        pred_q[tail_q] <= issue_pred_jump;
        // Entries resolved at issue never see the ALU, so they must
        // look correctly predicted.
        real_q[tail_q] <= issue_pred_jump;
      end
      if (lsb_ok) val_q[lsb_rob_pos] <= lsb_val;
      // ALU applied last so it wins if both buses target one entry.
      if (alu_ok) begin
        val_q[alu_rob_pos]    <= alu_val;
        real_q[alu_rob_pos]   <= alu_real_jump;
        resume_q[alu_rob_pos] <= alu_resume_pc;
      end
    end
  end

  // Operand queries: stored value first, then the buses (ALU before LSB).
  logic rs1_alu_hit, rs1_lsb_hit, rs2_alu_hit, rs2_lsb_hit;
  assign rs1_alu_hit = alu_result & (alu_rob_pos == rs1_rob_pos);
  assign rs1_lsb_hit = lsb_result & (lsb_rob_pos == rs1_rob_pos);
  assign rs2_alu_hit = alu_result & (alu_rob_pos == rs2_rob_pos);
  assign rs2_lsb_hit = lsb_result & (lsb_rob_pos == rs2_rob_pos);

  assign rs1_ready = ready_q[rs1_rob_pos] | rs1_alu_hit | rs1_lsb_hit;
  assign rs1_val   = ready_q[rs1_rob_pos] ? val_q[rs1_rob_pos] :
                     rs1_alu_hit ? alu_val : rs1_lsb_hit ? lsb_val : 32'd0;
  assign rs2_ready = ready_q[rs2_rob_pos] | rs2_alu_hit | rs2_lsb_hit;
  assign rs2_val   = ready_q[rs2_rob_pos] ? val_q[rs2_rob_pos] :
                     rs2_alu_hit ? alu_val : rs2_lsb_hit ? lsb_val : 32'd0;

  assign commit         = commit_q;
  assign commit_store   = commit_store_q;
  assign commit_rd      = commit_rd_q;
  assign commit_val     = commit_val_q;
  assign commit_rob_pos = commit_rob_pos_q;
  assign rollback       = rollback_q;
  assign rollback_pc    = rollback_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        issue, issue_pred_jump, issue_ready;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc, issue_val;
  logic [3:0]  issue_rob_pos;
  logic        full;
  logic        alu_result, alu_real_jump;
  logic [3:0]  alu_rob_pos;
  logic [31:0] alu_val, alu_resume_pc;
  logic        lsb_result;
  logic [3:0]  lsb_rob_pos;
  logic [31:0] lsb_val;
  logic [3:0]  rs1_rob_pos, rs2_rob_pos;
  logic        rs1_ready, rs2_ready;
  logic [31:0] rs1_val, rs2_val;
  logic        commit, commit_store, rollback;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val, rollback_pc;
  logic [3:0]  commit_rob_pos;

  int errors = 0;
  int checks = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue(issue), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump),
    .issue_ready(issue_ready), .issue_val(issue_val),
    .issue_rob_pos(issue_rob_pos), .full(full),
    .alu_result(alu_result), .alu_rob_pos(alu_rob_pos), .alu_val(alu_val),
    .alu_real_jump(alu_real_jump), .alu_resume_pc(alu_resume_pc),
    .lsb_result(lsb_result), .lsb_rob_pos(lsb_rob_pos), .lsb_val(lsb_val),
    .rs1_rob_pos(rs1_rob_pos), .rs1_ready(rs1_ready), .rs1_val(rs1_val),
    .rs2_rob_pos(rs2_rob_pos), .rs2_ready(rs2_ready), .rs2_val(rs2_val),
    .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_pos(commit_rob_pos), .commit_store(commit_store),
    .rollback(rollback), .rollback_pc(rollback_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rdy = 1'b1; issue = 1'b0; issue_type = 2'd0; issue_rd = 5'd0;
    issue_pc = 32'd0; issue_pred_jump = 1'b0; issue_ready = 1'b0;
    issue_val = 32'd0; alu_result = 1'b0; alu_rob_pos = 4'd0;
    alu_val = 32'd0; alu_real_jump = 1'b0; alu_resume_pc = 32'd0;
    lsb_result = 1'b0; lsb_rob_pos = 4'd0; lsb_val = 32'd0;
    rs1_rob_pos = 4'd0; rs2_rob_pos = 4'd0;
  endtask

  // Called just after an edge; reset pulse completes before the next edge.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (issue_rob_pos !== 4'd0) begin errors++; $display("FAIL reset_tail got=%0d exp=0", issue_rob_pos); end
    checks++; if (commit !== 1'b0 || rollback !== 1'b0) begin errors++; $display("FAIL reset_pulses commit=%0b rollback=%0b exp=0/0", commit, rollback); end
    rst = 1'b1;
    // Five ready entries flow through; then reset lands between edges.
    for (int i = 0; i < 5; i++) begin
      issue = 1'b1; issue_ready = 1'b1; issue_rd = 5'(i + 1); issue_val = 32'(i);
      tick();
    end
    issue = 1'b0;
    checks++; if (issue_rob_pos !== 4'd5 || commit !== 1'b1) begin errors++; $display("FAIL prereset tail=%0d commit=%0b exp=5/1", issue_rob_pos, commit); end
    rst = 1'b0;
    #1;
    checks++; if (issue_rob_pos !== 4'd0 || full !== 1'b0 || commit !== 1'b0) begin errors++; $display("FAIL async_reset tail=%0d full=%0b commit=%0b exp=0/0/0", issue_rob_pos, full, commit); end
    rst = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_fill_and_ooo();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue = 1'b1; issue_type = 2'd0; issue_rd = 5'(i + 1); issue_ready = 1'b0;
      tick();
    end
    checks++; if (full !== 1'b1 || issue_rob_pos !== 4'd0) begin errors++; $display("FAIL fill16 full=%0b tail=%0d exp=1/0", full, issue_rob_pos); end
    issue_rd = 5'd31;
    tick();
    issue = 1'b0;
    checks++; if (full !== 1'b1 || issue_rob_pos !== 4'd0 || commit !== 1'b0) begin errors++; $display("FAIL issue_when_full full=%0b tail=%0d commit=%0b exp=1/0/0", full, issue_rob_pos, commit); end
    alu_result = 1'b1; alu_rob_pos = 4'd0; alu_val = 32'h11;
    tick();
    alu_result = 1'b0;
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL wb_same_edge commit=%0b exp=0", commit); end
    tick();
    checks++; if (commit !== 1'b1 || commit_rob_pos !== 4'd0 || commit_rd !== 5'd1 || commit_val !== 32'h11 || full !== 1'b0)
      begin errors++; $display("FAIL first_commit c=%0b pos=%0d rd=%0d val=%h full=%0b exp=1/0/1/11/0", commit, commit_rob_pos, commit_rd, commit_val, full); end
    $display("commit pos=%0d rd=%0d val=%h", commit_rob_pos, commit_rd, commit_val);
    for (int p = 3; p >= 1; p--) begin
      alu_result = 1'b1; alu_rob_pos = 4'(p); alu_val = 32'(32'h100 + p);
      tick();
      checks++; if (commit !== 1'b0) begin errors++; $display("FAIL ooo_wait pos=%0d commit=%0b exp=0", p, commit); end
    end
    alu_result = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      tick();
      checks++; if (commit !== 1'b1 || commit_rob_pos !== 4'(p) || commit_val !== 32'(32'h100 + p) || commit_rd !== 5'(p + 1))
        begin errors++; $display("FAIL ooo_commit c=%0b pos=%0d val=%h rd=%0d exp=1/%0d/%h/%0d", commit, commit_rob_pos, commit_val, commit_rd, p, 32'h100 + p, p + 1); end
      $display("commit pos=%0d rd=%0d val=%h", commit_rob_pos, commit_rd, commit_val);
    end
    tick();
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL ooo_stop commit=%0b exp=0", commit); end
  endtask

  task automatic test_store();
    do_reset();
    issue = 1'b1; issue_type = 2'd1; issue_rd = 5'd7; issue_ready = 1'b0;
    tick();
    issue = 1'b0;
    lsb_result = 1'b1; lsb_rob_pos = 4'd0; lsb_val = 32'hAB;
    tick();
    lsb_result = 1'b0;
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL store_wait commit=%0b exp=0", commit); end
    tick();
    checks++; if (commit !== 1'b1 || commit_store !== 1'b1 || commit_rd !== 5'd0 || commit_rob_pos !== 4'd0)
      begin errors++; $display("FAIL store_commit c=%0b st=%0b rd=%0d pos=%0d exp=1/1/0/0", commit, commit_store, commit_rd, commit_rob_pos); end
    $display("store commit pos=%0d", commit_rob_pos);
    tick();
    checks++; if (commit_store !== 1'b0 || commit !== 1'b0) begin errors++; $display("FAIL store_pulse st=%0b c=%0b exp=0/0", commit_store, commit); end
  endtask

  task automatic test_rollback();
    do_reset();
    issue = 1'b1; issue_type = 2'd2; issue_rd = 5'd0; issue_pred_jump = 1'b0; issue_ready = 1'b0;
    tick();
    issue_type = 2'd0; issue_rd = 5'd4;
    for (int i = 0; i < 3; i++) tick();
    issue = 1'b0;
    alu_result = 1'b1; alu_rob_pos = 4'd0; alu_real_jump = 1'b1; alu_resume_pc = 32'h1000;
    tick();
    alu_result = 1'b0;
    checks++; if (rollback !== 1'b0) begin errors++; $display("FAIL rb_early rollback=%0b exp=0", rollback); end
    tick();
    checks++; if (commit !== 1'b1 || rollback !== 1'b1 || rollback_pc !== 32'h1000 || issue_rob_pos !== 4'd0 || full !== 1'b0)
      begin errors++; $display("FAIL rb_pulse c=%0b rb=%0b pc=%h tail=%0d full=%0b exp=1/1/1000/0/0", commit, rollback, rollback_pc, issue_rob_pos, full); end
    $display("rollback pc=%h", rollback_pc);
    issue = 1'b1; issue_ready = 1'b1; issue_rd = 5'd5; issue_val = 32'h77;
    tick();
    issue = 1'b0;
    checks++; if (issue_rob_pos !== 4'd0 || rollback !== 1'b0 || commit !== 1'b0) begin errors++; $display("FAIL rb_drop tail=%0d rb=%0b c=%0b exp=0/0/0", issue_rob_pos, rollback, commit); end
    tick();
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL rb_drop_commit c=%0b exp=0", commit); end
    issue = 1'b1; issue_ready = 1'b1; issue_rd = 5'd9; issue_val = 32'h99;
    tick();
    issue = 1'b0;
    tick();
    checks++; if (commit !== 1'b1 || commit_rd !== 5'd9 || commit_rob_pos !== 4'd0 || commit_val !== 32'h99)
      begin errors++; $display("FAIL post_flush c=%0b rd=%0d pos=%0d val=%h exp=1/9/0/99", commit, commit_rd, commit_rob_pos, commit_val); end
  endtask

  task automatic test_query();
    do_reset();
    issue = 1'b1; issue_type = 2'd0; issue_rd = 5'd1; issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    issue = 1'b0;
    rs1_rob_pos = 4'd3; rs2_rob_pos = 4'd2;
    alu_result = 1'b1; alu_rob_pos = 4'd3; alu_val = 32'hDEAD;
    #1;
    checks++; if (rs1_ready !== 1'b1 || rs1_val !== 32'hDEAD) begin errors++; $display("FAIL fwd_alu rdy=%0b val=%h exp=1/dead", rs1_ready, rs1_val); end
    checks++; if (rs2_ready !== 1'b0 || rs2_val !== 32'd0) begin errors++; $display("FAIL query_busy rdy=%0b val=%h exp=0/0", rs2_ready, rs2_val); end
    lsb_result = 1'b1; lsb_rob_pos = 4'd2; lsb_val = 32'hBEEF;
    #1;
    checks++; if (rs2_ready !== 1'b1 || rs2_val !== 32'hBEEF) begin errors++; $display("FAIL fwd_lsb rdy=%0b val=%h exp=1/beef", rs2_ready, rs2_val); end
    tick();
    alu_result = 1'b0; lsb_result = 1'b0;
    #1;
    checks++; if (rs1_ready !== 1'b1 || rs1_val !== 32'hDEAD || rs2_val !== 32'hBEEF)
      begin errors++; $display("FAIL stored_query r1=%0b v1=%h v2=%h exp=1/dead/beef", rs1_ready, rs1_val, rs2_val); end
    $display("query rs1=%h rs2=%h", rs1_val, rs2_val);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      issue = 1'b1; issue_ready = 1'b1; issue_rd = 5'd1; issue_val = 32'(i);
      tick();
    end
    issue = 1'b0;
    tick();
    tick();
    checks++; if (issue_rob_pos !== 4'd14 || commit !== 1'b0) begin errors++; $display("FAIL wrap_prep tail=%0d c=%0b exp=14/0", issue_rob_pos, commit); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (issue_rob_pos !== 4'((14 + k) % 16)) begin errors++; $display("FAIL wrap_tail got=%0d exp=%0d", issue_rob_pos, (14 + k) % 16); end
      issue = 1'b1; issue_ready = 1'b0; issue_rd = 5'(10 + k);
      tick();
    end
    issue = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      alu_result = 1'b1; alu_rob_pos = 4'((14 + k) % 16); alu_val = 32'(32'h200 + k);
      tick();
    end
    alu_result = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (commit !== 1'b1 || commit_rob_pos !== 4'((14 + k) % 16) || commit_val !== 32'(32'h200 + k) || commit_rd !== 5'(10 + k))
        begin errors++; $display("FAIL wrap_commit c=%0b pos=%0d val=%h rd=%0d exp=1/%0d/%h/%0d", commit, commit_rob_pos, commit_val, commit_rd, (14 + k) % 16, 32'h200 + k, 10 + k); end
      $display("commit pos=%0d rd=%0d val=%h", commit_rob_pos, commit_rd, commit_val);
    end
  endtask

  task automatic test_rdy_hold();
    do_reset();
    issue = 1'b1; issue_ready = 1'b1; issue_rd = 5'd3; issue_val = 32'h55;
    tick();
    issue = 1'b0; rdy = 1'b0;
    tick();
    checks++; if (commit !== 1'b0 || issue_rob_pos !== 4'd1) begin errors++; $display("FAIL stall_hold c=%0b tail=%0d exp=0/1", commit, issue_rob_pos); end
    rdy = 1'b1;
    tick();
    checks++; if (commit !== 1'b1 || commit_val !== 32'h55 || commit_rd !== 5'd3) begin errors++; $display("FAIL stall_release c=%0b val=%h rd=%0d exp=1/55/3", commit, commit_val, commit_rd); end
    rdy = 1'b0;
    tick();
    checks++; if (commit !== 1'b1) begin errors++; $display("FAIL stall_pulse_hold c=%0b exp=1", commit); end
    rdy = 1'b1;
    tick();
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL stall_pulse_end c=%0b exp=0", commit); end
    $display("rdy hold test done");
  endtask

  initial begin
    test_reset();
    test_fill_and_ooo();
    test_store();
    test_rollback();
    test_query();
    test_wrap();
    test_rdy_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
16-entry circular reorder buffer between the decoder/execution units and the register file. It allocates one entry per issued instruction and collects results from the ALU and load/store buffer (LSB) write-back buses. It retires at most one instruction per cycle, in program order, to the register file. On a mispredicted branch or JALR it raises a flush (rollback) to every stage.

Parameters:
ROB_SIZE, 16, entry count (power of two)
ROB_W, 4, log2(ROB_SIZE); width of every rob_pos field

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; when 0, all state holds
issue  in  1  decoder allocates an entry this cycle
issue_type  in  2  ROB_REG / ROB_STORE / ROB_BR
issue_rd  in  5  destination register (0 = none)
issue_pc  in  32  instruction PC
issue_pred_jump  in  1  predictor decision (branch/JALR)
issue_ready  in  1  result already known at issue (LUI/AUIPC/JAL)
issue_val  in  32  value when issue_ready=1
issue_rob_pos  out  4  tail index handed to decoder/RegFile (combinational)
full  out  1  no free entry; decoder must not issue
alu_result  in  1  ALU write-back valid
alu_rob_pos  in  4  target entry
alu_val  in  32  result value
alu_real_jump  in  1  resolved branch direction
alu_resume_pc  in  32  correct next PC if mispredicted
lsb_result  in  1  LSB write-back valid (load data or store address ready)
lsb_rob_pos  in  4  target entry
lsb_val  in  32  load data
rs1_rob_pos  in  4  decoder query index
rs1_ready  out  1  queried entry has a value (combinational)
rs1_val  out  32  queried value
rs2_rob_pos  in  4  second query index
rs2_ready  out  1  as rs1
rs2_val  out  32  as rs1
commit  out  1  one-cycle retirement pulse (registered)
commit_rd  out  5  destination register; 0 for stores and plain branches
commit_val  out  32  value written back
commit_rob_pos  out  4  retired entry index
commit_store  out  1  pulse: LSB may perform the store at commit_rob_pos
rollback  out  1  one-cycle flush pulse (registered)
rollback_pc  out  32  fetch redirect target, valid with rollback

Behaviour:
- Reset (rst=0, asynchronous): head=tail=count=0; all busy/ready bits 0; all registered outputs 0.
- rdy=0: no state change; registered outputs hold.
- full = (count==ROB_SIZE). issue_rob_pos = tail.
- Issue (issue & !full & !rollback): write the entry at tail; busy=1; ready=issue_ready; tail+1 mod 16. Issue while full is ignored.
- Write-back: alu_result/lsb_result sets ready=1 and val at the addressed entry. The ALU bus also stores real_jump and resume_pc. Write-back to a non-busy entry is ignored. Both buses may hit different entries in the same cycle. Both hitting one entry is illegal; if it occurs, the ALU bus wins.
- Retirement is evaluated every edge; commit, commit_store and rollback are otherwise 0.
  - Condition: count!=0 and head entry busy & ready.
  - Effect: commit=1, commit_rd/val/rob_pos loaded, head+1, busy cleared.
  - ROB_STORE: commit_store=1, commit_rd=0.
  - ROB_BR: if pred_jump != real_jump, then rollback=1 and rollback_pc=resume_pc.
- A write-back arriving in the same cycle the head is examined does not retire that edge; it retires on the next edge. Minimum issue-to-commit latency is 1 cycle (issue_ready=1 entry at head).
- Mispredict: on the same edge that retires the branch, all busy bits clear and head=tail=count=0. During the cycle rollback=1, issue and both write-back buses are ignored.
- count update: +1 on issue, -1 on retire, unchanged if both. Issue is still blocked when full, even if a retire happens the same cycle.
- Query (combinational): rsX_ready=1 when the entry is ready, or when the alu/lsb bus addresses it this cycle (bus value forwarded, ALU first); otherwise 0 and rsX_val=0.
- Pointer wrap: 15 -> 0 by natural 4-bit overflow.

Decomposition:
- Shared constants header (constant.v): ROB_REG=2'd0, ROB_STORE=2'd1, ROB_BR=2'd2, ROB_SIZE, ROB_W.
- Single module; no sub-module is warranted. Entry storage is a set of per-field arrays indexed by rob_pos.

Test Plan:
- Reset mid-run: fill 5 entries, pull rst low between edges -> full=0, issue_rob_pos=0, commit=0 immediately (async).
- Issue 16 ROB_REG with issue_ready=0 -> full=1 after 16th; 17th issue ignored. ALU write-back pos 0 val 0x11 -> commit=1, commit_rob_pos=0, commit_rd=issue_rd, commit_val=0x11 one edge later; full drops.
- Out-of-order completion: write back pos 2, then 1, then 0 -> commits appear in order 0,1,2 on consecutive cycles.
- Store at head with lsb_result -> commit_store=1, commit_rd=0, commit_rob_pos=store index.
- Branch pred_jump=0, ALU real_jump=1, resume_pc=0x1000, three younger entries busy -> commit and rollback pulse together, rollback_pc=0x1000; next cycle count=0, issue_rob_pos=0; issue during the rollback cycle is dropped.
- Query pos 3 while alu_rob_pos=3 in the same cycle with val 0xDEAD -> rs1_ready=1, rs1_val=0xDEAD combinationally; 4 issues/retires through wrap 15->0 keep correct ordering.
